bs_tx_serializer: RTL

//   Parallel-to-bit-serial transmitter for the modmul_bs datapath. Accepts WIDTH-bit words over a

---
 rtl/bs_tx_serializer_if.sv | 13 +
 rtl/bs_tx_serializer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bs_tx_serializer_if.sv
// Word-in / bit-serial-out bundle of bs_tx_serializer.
// The master is the word producer. The slave is the serializer.
interface bs_tx_serializer_if #(parameter int WIDTH = 10);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             qs;
   logic             osync;
   logic             busy;

   modport master (output din, din_valid, input din_ready, qs, osync, busy);
   modport slave  (input din, din_valid, output din_ready, qs, osync, busy);
endinterface

// File: rtl/bs_tx_serializer.sv
// LSB-first serializer: 1-cycle accept-to-LSB, gapless frames via shifter + hold register, ready = hold empty.
// BS_TX_ZEROPAD_EN appends PAD zero bits per frame (frame length WIDTH+PAD instead of WIDTH).
module bs_tx_serializer #(
   parameter int WIDTH     = 10,
   parameter int LOG2WIDTH = 4,
   parameter int PAD       = 2
) (
   input  logic              clk,
   input  logic              reset,
   bs_tx_serializer_if.slave bus
);

`ifdef BS_TX_ZEROPAD_EN
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PAD} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

   localparam logic [LOG2WIDTH-1:0] LAST_BIT = LOG2WIDTH'(WIDTH - 1);
`ifdef BS_TX_ZEROPAD_EN
   localparam logic [LOG2WIDTH-1:0] LAST_PAD = LOG2WIDTH'(PAD - 1);
`endif

   if ((2 ** LOG2WIDTH) < (WIDTH + PAD)) begin : g_bad_cnt_width
      $error("bs_tx_serializer: LOG2WIDTH too small for WIDTH+PAD");
   end

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     sh_q, sh_d;
   logic [WIDTH-1:0]     hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic [LOG2WIDTH-1:0] cnt_q, cnt_d;
   logic                 qs_q, qs_d;
   logic                 osync_q, osync_d;

   logic                 accept;
   logic                 boundary;
   logic                 start;
   logic                 start_din;
   logic [WIDTH-1:0]     src;

   assign bus.din_ready = ~hold_full_q;
   assign bus.qs        = qs_q;
   assign bus.osync     = osync_q;
   assign bus.busy      = (state_q != ST_IDLE) | hold_full_q;
   assign accept        = bus.din_valid & ~hold_full_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         sh_q        <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         qs_q        <= 1'b0;
         osync_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         sh_q        <= sh_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
         qs_q        <= qs_d;
         osync_q     <= osync_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sh_d        = sh_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;
      qs_d        = 1'b0;
      osync_d     = 1'b0;
      boundary    = 1'b0;
      start       = 1'b0;
      start_din   = 1'b0;
      src         = bus.din;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               start     = 1'b1;
               start_din = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == LAST_BIT) begin
`ifdef BS_TX_ZEROPAD_EN
               state_d = ST_PAD;
               cnt_d   = '0;
`else
               boundary = 1'b1;
`endif
            end else begin
               qs_d  = sh_q[0];
               sh_d  = sh_q >> 1;
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef BS_TX_ZEROPAD_EN
         ST_PAD: begin
            if (cnt_q == LAST_PAD) begin
               boundary = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Frame boundary: a waiting hold word has priority over a same-cycle bypass.
      if (boundary) begin
         if (hold_full_q) begin
            start       = 1'b1;
            src         = hold_q;
            hold_full_d = 1'b0;
         end else if (accept) begin
            start     = 1'b1;
            start_din = 1'b1;
         end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      end

      if (accept && !start_din) begin
         hold_d      = bus.din;
         hold_full_d = 1'b1;
      end

      if (start) begin
         state_d = ST_SHIFT;
         qs_d    = src[0];
         sh_d    = src >> 1;
         osync_d = 1'b1;
         cnt_d   = '0;
      end
   end

endmodule
